// File: rtl/cont_updown_if.sv
// Control/status bundle for the up/down modulo counter.
// master drives the controls, slave is the counter itself.
interface cont_updown_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             enable;
    logic             updown;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             wrap;

    modport master (
        output clr, load, d, enable, updown,
        input  Q, TC, wrap
    );

    modport slave (
        input  clr, load, d, enable, updown,
        output Q, TC, wrap
    );
endinterface

// File: rtl/cont_updown_mod.sv
// Parametrised synchronous up/down modulo counter with load, clear and wrap flag.
// Define CONT_SATURATE_EN to saturate at the ends instead of wrapping.
module cont_updown_mod #(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 256
) (
    input  logic          clk,
    input  logic          reset,
    cont_updown_if.slave  bus
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("cont_updown_mod: WIDTH out of range 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("cont_updown_mod: MODULUS out of range 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             wrap_q;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;
    logic             d_over;

    assign at_max  = (q == MAX);
    assign at_zero = (q == '0);
    // Widen before comparing so MODULUS == 2**WIDTH never clamps.
    assign d_over  = ({{(64-WIDTH){1'b0}}, bus.d} > (MODULUS - 64'd1));

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (bus.clr) begin
            q_next = '0;
        end else if (bus.load) begin
            q_next = d_over ? MAX : bus.d;
        end else if (bus.enable) begin
            if (bus.updown) begin
                if (at_max) begin
`ifdef CONT_SATURATE_EN
                    q_next = q;
`else
                    q_next    = '0;
                    wrap_next = 1'b1;
`endif
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef CONT_SATURATE_EN
                    q_next = q;
`else
                    q_next    = MAX;
                    wrap_next = 1'b1;
`endif
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            wrap_q <= 1'b0;
        end else begin
            q      <= q_next;
            wrap_q <= wrap_next;
        end
    end

    assign bus.Q    = q;
    assign bus.wrap = wrap_q;
    assign bus.TC   = bus.enable & (bus.updown ? at_max : at_zero);
endmodule

// File: tb/tb_cont_updown_mod.sv
// Directed self-checking bench for cont_updown_mod.
// Main instance WIDTH=4/MODULUS=10, plus a two-stage MODULUS=16 cascade.
module tb_cont_updown_mod;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    cont_updown_if #(.WIDTH(4)) u_if ();
    cont_updown_if #(.WIDTH(4)) c0_if ();
    cont_updown_if #(.WIDTH(4)) c1_if ();

    cont_updown_mod #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );
    cont_updown_mod #(.WIDTH(4), .MODULUS(16)) u_c0 (
        .clk   (clk),
        .reset (reset),
        .bus   (c0_if.slave)
    );
    cont_updown_mod #(.WIDTH(4), .MODULUS(16)) u_c1 (
        .clk   (clk),
        .reset (reset),
        .bus   (c1_if.slave)
    );

    assign c1_if.enable = c0_if.TC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.clr = 1'b0; u_if.load = 1'b1; u_if.d = 4'd5;
        u_if.enable = 1'b1; u_if.updown = 1'b1;
        tick(); tick();
        n_cmp++;
        if (u_if.Q !== 4'd0) begin
            n_fail++; $display("FAIL reset_q got=%0d exp=0", u_if.Q);
        end
        n_cmp++;
        if (u_if.wrap !== 1'b0) begin
            n_fail++; $display("FAIL reset_wrap got=%b exp=0", u_if.wrap);
        end
        reset = 1'b0; u_if.load = 1'b0;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd1) begin
            n_fail++; $display("FAIL reset_release_q got=%0d exp=1", u_if.Q);
        end
    endtask

    task automatic test_count_up();
        u_if.clr = 1'b1; u_if.enable = 1'b0;
        tick();
        u_if.clr = 1'b0; u_if.enable = 1'b1; u_if.updown = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            n_cmp++;
            if (u_if.TC !== (i == 10)) begin
                n_fail++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, u_if.TC, (i == 10));
            end
            tick();
            n_cmp++;
            if (u_if.Q !== 4'(i % 10)) begin
                n_fail++; $display("FAIL up_q step=%0d got=%0d exp=%0d", i, u_if.Q, i % 10);
            end
            n_cmp++;
            if (u_if.wrap !== (i == 10)) begin
                n_fail++; $display("FAIL up_wrap step=%0d got=%b exp=%b", i, u_if.wrap, (i == 10));
            end
        end
        u_if.enable = 1'b0;
        tick();
        n_cmp++;
        if (u_if.wrap !== 1'b0 || u_if.Q !== 4'd0) begin
            n_fail++; $display("FAIL up_hold got q=%0d wrap=%b exp q=0 wrap=0", u_if.Q, u_if.wrap);
        end
    endtask

    task automatic test_count_down();
        u_if.enable = 1'b1; u_if.updown = 1'b0;
        #1;
        n_cmp++;
        if (u_if.TC !== 1'b1) begin
            n_fail++; $display("FAIL down_tc got=%b exp=1", u_if.TC);
        end
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd9 || u_if.wrap !== 1'b1) begin
            n_fail++; $display("FAIL down_wrap got q=%0d wrap=%b exp q=9 wrap=1", u_if.Q, u_if.wrap);
        end
        u_if.updown = 1'b1;
        #1;
        n_cmp++;
        if (u_if.TC !== 1'b1) begin
            n_fail++; $display("FAIL dir_tc got=%b exp=1", u_if.TC);
        end
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd0 || u_if.wrap !== 1'b1) begin
            n_fail++; $display("FAIL dir_up got q=%0d wrap=%b exp q=0 wrap=1", u_if.Q, u_if.wrap);
        end
        u_if.updown = 1'b0; u_if.enable = 1'b0;
        #1;
        n_cmp++;
        if (u_if.TC !== 1'b0) begin
            n_fail++; $display("FAIL tc_no_en got=%b exp=0", u_if.TC);
        end
        tick();
        n_cmp++;
        if (u_if.wrap !== 1'b0) begin
            n_fail++; $display("FAIL down_hold_wrap got=%b exp=0", u_if.wrap);
        end
        u_if.enable = 1'b1;
        tick(); tick();
        n_cmp++;
        if (u_if.Q !== 4'd8) begin
            n_fail++; $display("FAIL down_step got=%0d exp=8", u_if.Q);
        end
    endtask

    task automatic test_load();
        u_if.load = 1'b1; u_if.d = 4'd5; u_if.enable = 1'b1; u_if.updown = 1'b1;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd5 || u_if.wrap !== 1'b0) begin
            n_fail++; $display("FAIL load5 got q=%0d wrap=%b exp q=5 wrap=0", u_if.Q, u_if.wrap);
        end
        u_if.d = 4'd14;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd9) begin
            n_fail++; $display("FAIL load_clamp got=%0d exp=9", u_if.Q);
        end
        u_if.d = 4'd2;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd2 || u_if.wrap !== 1'b0) begin
            n_fail++; $display("FAIL load_over_wrap got q=%0d wrap=%b exp q=2 wrap=0", u_if.Q, u_if.wrap);
        end
        u_if.clr = 1'b1; u_if.d = 4'd3;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd0) begin
            n_fail++; $display("FAIL clr_load got=%0d exp=0", u_if.Q);
        end
        u_if.clr = 1'b0; u_if.d = 4'd7;
        tick();
        reset = 1'b1; u_if.clr = 1'b1;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd0) begin
            n_fail++; $display("FAIL rst_clr_load got=%0d exp=0", u_if.Q);
        end
        reset = 1'b0; u_if.clr = 1'b0; u_if.load = 1'b0; u_if.enable = 1'b0;
        tick();
    endtask

    task automatic test_clr_wrap();
        u_if.load = 1'b1; u_if.d = 4'd9;
        tick();
        u_if.load = 1'b0; u_if.enable = 1'b1; u_if.updown = 1'b1;
        tick();
        u_if.clr = 1'b1;
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd0 || u_if.wrap !== 1'b0) begin
            n_fail++; $display("FAIL clr_wrap got q=%0d wrap=%b exp q=0 wrap=0", u_if.Q, u_if.wrap);
        end
        u_if.clr = 1'b0; u_if.enable = 1'b0;
    endtask

    task automatic test_cascade();
        int w0;
        int w1;
        w0 = 0; w1 = 0;
        c0_if.enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0; c0_if.enable = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (c0_if.wrap) w0++;
            if (c1_if.wrap) w1++;
            if (i == 17) begin
                n_cmp++;
                if (c0_if.Q !== 4'd1 || c1_if.Q !== 4'd1) begin
                    n_fail++; $display("FAIL casc_mid got q0=%0d q1=%0d exp 1 1", c0_if.Q, c1_if.Q);
                end
            end
        end
        n_cmp++;
        if (c0_if.Q !== 4'd0 || c1_if.Q !== 4'd0) begin
            n_fail++; $display("FAIL casc_end got q0=%0d q1=%0d exp 0 0", c0_if.Q, c1_if.Q);
        end
        n_cmp++;
        if (w1 !== 1) begin
            n_fail++; $display("FAIL casc_wrap1 got=%0d exp=1", w1);
        end
        n_cmp++;
        if (w0 !== 16) begin
            n_fail++; $display("FAIL casc_wrap0 got=%0d exp=16", w0);
        end
        c0_if.enable = 1'b0;
    endtask

    task automatic test_saturate();
        u_if.clr = 1'b1; u_if.enable = 1'b0;
        tick();
        u_if.clr = 1'b0; u_if.enable = 1'b1; u_if.updown = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_cmp++;
            if (u_if.Q !== 4'((i < 9) ? i : 9) || u_if.wrap !== 1'b0) begin
                n_fail++; $display("FAIL sat_up step=%0d got q=%0d wrap=%b", i, u_if.Q, u_if.wrap);
            end
        end
        n_cmp++;
        if (u_if.TC !== 1'b1) begin
            n_fail++; $display("FAIL sat_tc got=%b exp=1", u_if.TC);
        end
        u_if.clr = 1'b1;
        tick();
        u_if.clr = 1'b0; u_if.updown = 1'b0;
        #1;
        n_cmp++;
        if (u_if.TC !== 1'b1) begin
            n_fail++; $display("FAIL sat_down_tc got=%b exp=1", u_if.TC);
        end
        tick();
        n_cmp++;
        if (u_if.Q !== 4'd0 || u_if.wrap !== 1'b0) begin
            n_fail++; $display("FAIL sat_down got q=%0d wrap=%b exp q=0 wrap=0", u_if.Q, u_if.wrap);
        end
        u_if.enable = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        u_if.clr = 1'b0; u_if.load = 1'b0; u_if.d = '0;
        u_if.enable = 1'b0; u_if.updown = 1'b1;
        c0_if.clr = 1'b0; c0_if.load = 1'b0; c0_if.d = '0;
        c0_if.enable = 1'b0; c0_if.updown = 1'b1;
        c1_if.clr = 1'b0; c1_if.load = 1'b0; c1_if.d = '0;
        c1_if.updown = 1'b1;
        test_reset();
        test_load();
`ifdef CONT_SATURATE_EN
        test_saturate();
`else
        test_count_up();
        test_count_down();
        test_clr_wrap();
        test_cascade();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
